// File: rtl/xs3_to_bin_seq.sv
// xs3_to_bin_seq
// Sequential Excess-3 to binary converter. A packed word of DIGITS Excess-3
// nibbles is accepted through a valid/ready handshake and converted one digit
// per clock, most significant digit first, with acc = acc*10 + (nibble - 3)
// evaluated modulo 2^BIN_W. Nibbles outside 0011..1100 contribute zero and
// are flagged individually and through a sticky word-level flag.
//
// Parameters
//   DIGITS  number of Excess-3 digits per word (1..8)
//   BIN_W   binary result width, at least ceil(log2(10^DIGITS))
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   in_valid       input word presented
//   in_ready       block accepts a word this cycle (high only when idle)
//   in_xs3         packed digits, MSD in the top nibble
//   out_valid      result presented (held until out_ready)
//   out_ready      consumer accepts the result
//   out_bin        binary value
//   out_invalid    at least one nibble was outside 0011..1100
//   out_bad_digit  bit i set when nibble i (in_xs3[4i+3:4i]) was invalid
//   err_cnt        (only with XS3B_ERR_CNT_EN) saturating 16-bit count of
//                  completed words whose out_invalid was set
//
// Optional feature macro: XS3B_ERR_CNT_EN

module xs3_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_xs3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_invalid,
  output logic [DIGITS-1:0]     out_bad_digit
`ifdef XS3B_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot pointer starting at the MSD; it doubles as the digit counter and
  // as the bit to set in the bad-digit vector.
  localparam logic [DIGITS-1:0] MSD_MASK = DIGITS'(1) << (DIGITS - 1);

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic                  invalid_q, invalid_d;
  logic [DIGITS-1:0]     bad_q, bad_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic [3:0]            nib;
  logic                  nib_ok;
  logic [3:0]            dval;

`ifdef XS3B_ERR_CNT_EN
  logic [15:0]           err_cnt_q, err_cnt_d;
`endif

  // The word is shifted left each CONV cycle so the digit being processed
  // always sits in the top nibble.
  always_comb begin
    nib    = word_q[4*DIGITS-1 -: 4];
    nib_ok = (nib >= 4'd3) && (nib <= 4'd12);
    dval   = nib_ok ? (nib - 4'd3) : 4'd0;
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
    invalid_d   = invalid_q;
    bad_d       = bad_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          word_d     = in_xs3;
          mask_d     = MSD_MASK;
          acc_d      = '0;
          invalid_d  = 1'b0;
          bad_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        // acc*10 as (acc<<3)+(acc<<1); truncation gives the modulo wrap.
        acc_d  = (acc_q << 3) + (acc_q << 1) + BIN_W'(dval);
        word_d = word_q << 4;
        mask_d = mask_q >> 1;
        if (!nib_ok) begin
          bad_d     = bad_q | mask_q;
          invalid_d = 1'b1;
        end
        if (mask_q[0]) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

`ifdef XS3B_ERR_CNT_EN
  // Counts completed words carrying the invalid flag, saturating.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == DONE) && out_ready && invalid_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
      invalid_q   <= 1'b0;
      bad_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef XS3B_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      invalid_q   <= invalid_d;
      bad_q       <= bad_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef XS3B_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_bin       = acc_q;
  assign out_invalid   = invalid_q;
  assign out_bad_digit = bad_q;
`ifdef XS3B_ERR_CNT_EN
  assign err_cnt       = err_cnt_q;
`endif

endmodule

// File: tb/tb_xs3_to_bin_seq.sv
// tb_xs3_to_bin_seq
// Self-checking bench for xs3_to_bin_seq with DIGITS=4, BIN_W=14.
// Directed table vectors, hand-written stall/reset sequences, and a random
// back-to-back stream scored against an integer reference model.

module tb_xs3_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_xs3;
  logic              out_valid;
  logic              out_ready;
  logic [13:0]       out_bin;
  logic              out_invalid;
  logic [3:0]        out_bad_digit;
`ifdef XS3B_ERR_CNT_EN
  logic [15:0]       err_cnt;
  int                exp_err = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  xs3_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_xs3        (in_xs3),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bin       (out_bin),
    .out_invalid   (out_invalid),
    .out_bad_digit (out_bad_digit)
`ifdef XS3B_ERR_CNT_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Generic comparison: counts every check, reports failures.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: decimal value of the valid digits, invalid ones count 0.
  function automatic void refModel(input logic [15:0] w, output logic [13:0] bin,
                                   output logic inv, output logic [3:0] bad);
    int val;
    int n;
    val = 0;
    inv = 1'b0;
    bad = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      n = int'((w >> (4 * i)) & 16'hF);
      if (n >= 3 && n <= 12) begin
        val = val * 10 + (n - 3);
      end else begin
        val = val * 10;
        bad[i] = 1'b1;
        inv = 1'b1;
      end
    end
    bin = 14'(val % 16384);
  endfunction

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 7) == 0) w[4*i +: 4] = 4'($urandom_range(0, 15));
      else                           w[4*i +: 4] = 4'($urandom_range(3, 12));
    end
    return w;
  endfunction

  // Presents one word, waits for acceptance, then measures the number of
  // edges after the acceptance edge until out_valid appears.
  task automatic applyStimulus(input logic [15:0] w, output int lat);
    in_xs3   = w;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Scoreboard for the random stream, sampled on the falling edge so the
  // signals seen are those the next rising edge will act on.
  logic [15:0] sb_q[$];
  int          accept_cyc[$];
  int          cyc = 0;
  int          n_results = 0;
  bit          sb_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [13:0] eb;
    logic        ei;
    logic [3:0]  ed;
    logic [15:0] w;
    if (sb_en && !rst) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(in_xs3);
        accept_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        checkOutput("sb_expected_word", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          w = sb_q.pop_front();
          refModel(w, eb, ei, ed);
          checkOutput("sb_out_bin", 32'(out_bin), 32'(eb));
          checkOutput("sb_out_invalid", 32'(out_invalid), 32'(ei));
          checkOutput("sb_out_bad_digit", 32'(out_bad_digit), 32'(ed));
          n_results++;
        end
      end
    end
  end

  typedef struct {
    logic [15:0] xs3;
    logic [13:0] bin;
    logic        inv;
    logic [3:0]  bad;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int cnt;
    int sent;
    int guard;

    vecs[0] = '{16'h4C73, 14'd1940, 1'b0, 4'b0000};
    vecs[1] = '{16'hCCCC, 14'd9999, 1'b0, 4'b0000};
    vecs[2] = '{16'h3333, 14'd0,    1'b0, 4'b0000};
    vecs[3] = '{16'h4404, 14'd1101, 1'b1, 4'b0010};
    vecs[4] = '{16'h0000, 14'd0,    1'b1, 4'b1111};
    vecs[5] = '{16'h5A89, 14'd2756, 1'b0, 4'b0000};
    vecs[6] = '{16'h3D3C, 14'd9,    1'b1, 4'b0100};
    vecs[7] = '{16'hF2C3, 14'd90,   1'b1, 4'b1100};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_xs3    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_bin", 32'(out_bin), 32'd0);
    checkOutput("reset_out_invalid", 32'(out_invalid), 32'd0);
    checkOutput("reset_out_bad_digit", 32'(out_bad_digit), 32'd0);
`ifdef XS3B_ERR_CNT_EN
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].xs3, lat);
      checkOutput("tbl_latency", 32'(lat), 32'(DIGITS));
      checkOutput("tbl_out_bin", 32'(out_bin), 32'(vecs[i].bin));
      checkOutput("tbl_out_invalid", 32'(out_invalid), 32'(vecs[i].inv));
      checkOutput("tbl_out_bad_digit", 32'(out_bad_digit), 32'(vecs[i].bad));
      checkOutput("tbl_in_ready_done", 32'(in_ready), 32'd0);
      handshake();
`ifdef XS3B_ERR_CNT_EN
      if (vecs[i].inv) exp_err++;
      checkOutput("tbl_err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
      checkOutput("tbl_out_valid_after_hs", 32'(out_valid), 32'd0);
      checkOutput("tbl_in_ready_after_hs", 32'(in_ready), 32'd1);
      checkOutput("tbl_out_bin_held", 32'(out_bin), 32'(vecs[i].bin));
      checkOutput("tbl_bad_held", 32'(out_bad_digit), 32'(vecs[i].bad));
    end

    // Consumer stalls in DONE while a new word is offered.
    applyStimulus(16'h4C73, lat);
    in_xs3   = 16'hCCCC;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_bin", 32'(out_bin), 32'd1940);
    end
    in_valid = 1'b0;
    handshake();
    checkOutput("stall_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("stall_release_out_valid", 32'(out_valid), 32'd0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    checkOutput("stall_no_extra_word", 32'(cnt), 32'd0);
    checkOutput("stall_result_held", 32'(out_bin), 32'd1940);

    // Reset during the second CONV cycle.
    in_xs3   = 16'h5A89;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_conv_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_conv_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_conv_out_bin", 32'(out_bin), 32'd0);
    checkOutput("rst_conv_out_invalid", 32'(out_invalid), 32'd0);
    checkOutput("rst_conv_bad", 32'(out_bad_digit), 32'd0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    checkOutput("rst_conv_no_out_valid", 32'(cnt), 32'd0);
    applyStimulus(16'h4404, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'(DIGITS));
    checkOutput("post_rst_out_bin", 32'(out_bin), 32'd1101);
    checkOutput("post_rst_bad", 32'(out_bad_digit), 32'b0010);
    handshake();

    // Reset while a result waits in DONE.
    applyStimulus(16'hCCCC, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_done_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_done_out_bin", 32'(out_bin), 32'd0);
    checkOutput("rst_done_in_ready", 32'(in_ready), 32'd1);
`ifdef XS3B_ERR_CNT_EN
    exp_err = 0;
    checkOutput("rst_done_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Random back-to-back stream with the consumer always ready.
    sb_en     = 1'b1;
    out_ready = 1'b1;
    sent      = 0;
    guard     = 0;
    while (sent < 20 && guard < 400) begin
      if (in_ready) begin
        in_xs3   = randWord();
        in_valid = 1'b1;
        sent++;
      end
      if (sent < 20) begin
        @(posedge clk); #1;
      end
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (n_results < 20 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("stream_result_count", 32'(n_results), 32'd20);
    checkOutput("stream_queue_empty", 32'(sb_q.size()), 32'd0);
    for (int i = 1; i < accept_cyc.size(); i++) begin
      checkOutput("stream_accept_spacing", 32'(accept_cyc[i] - accept_cyc[i-1]), 32'(DIGITS + 2));
    end
    sb_en     = 1'b0;
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
